// File: rtl/bit_serial_logic_ctrl_pkg.sv
// rtl/bit_serial_logic_ctrl_pkg.sv - shared opcodes and FSM state encoding for the bit-serial logic unit
package bit_serial_logic_ctrl_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_logic_ctrl_cell.sv
// rtl/bit_serial_logic_ctrl_cell.sv - single-bit logic cell (AND/OR/XOR/NOR), the shared resource being sequenced
//   a, b : operand bits
//   op   : operation select (OP_AND/OP_OR/OP_XOR/OP_NOR)
//   y    : result bit
module logic_cell_1bit
    import bit_serial_logic_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/bit_serial_logic_ctrl.sv
// rtl/bit_serial_logic_ctrl.sv - sequences one 1-bit logic cell across a WIDTH-bit operand pair, LSB first
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or DONE
//   op, A, B   : operation and operands, latched on acceptance
//   busy       : high while bits are processed (WIDTH cycles)
//   done       : one-cycle pulse when a new Z is valid
//   Z, ZERO    : registered result and (Z == 0) flag, updated only on completion
module bit_serial_logic_ctrl
    import bit_serial_logic_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             ZERO
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] z_r;
    logic             zero_r;
    logic             bit_y;
    logic             accept;
    logic             last_bit;

    // A request is only seen when no operation is in flight; DONE doubles
    // as an accept slot so back-to-back requests lose no extra cycle.
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (state_q == S_RUN) && (cnt == LAST_IDX);

    logic_cell_1bit u_cell (
        .a  (a_r[cnt]),
        .b  (b_r[cnt]),
        .op (op_r),
        .y  (bit_y)
    );

    // Result word including the bit being produced this cycle, so the final
    // bit lands in Z on the same edge it is computed.
    always_comb begin
        res_next      = res_r;
        res_next[cnt] = bit_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 2'b00;
            res_r  <= '0;
            cnt    <= '0;
            z_r    <= '0;
            zero_r <= 1'b1;
        end else if (accept) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= op;
            cnt  <= '0;
        end else if (state_q == S_RUN) begin
            res_r <= res_next;
            if (last_bit) begin
                // Counter parks at 0 rather than wrapping past WIDTH-1.
                cnt    <= '0;
                z_r    <= res_next;
                zero_r <= (res_next == '0);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign Z    = z_r;
    assign ZERO = zero_r;

endmodule

// File: tb/tb_bit_serial_logic_ctrl.sv
// tb/tb_bit_serial_logic_ctrl.sv - self-checking bench for bit_serial_logic_ctrl
module tb_bit_serial_logic_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serial_logic_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Z     (z),
        .ZERO  (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Word-level model: an accepted request occupies the unit for W cycles,
    // then the whole-word result appears together with a one-cycle done.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_z    = '0;
    logic [W-1:0] m_pend = '0;
    int           cyc    = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_z    = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_z    = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = word_op(op, a, b);
                m_left = W;
            end
        end
    end

    bit chk_en   = 1'b0;
    int n_done   = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_vs_model", busy, m_left > 0);
            check("done_vs_model", done, m_done);
            check("z_vs_model", z, m_z);
            check("zero_vs_model", zero, m_z == '0);
            if (done) n_done++;
            if (busy) busy_cnt++;
        end
    end

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_z, input logic exp_zero, input string name);
        int d0;
        @(negedge clk);
        busy_cnt = 0;
        d0 = n_done;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done({name, "_done"});
        check({name, "_z"}, z, exp_z);
        check({name, "_zero"}, zero, exp_zero);
        @(negedge clk);
        check({name, "_busy_cycles"}, busy_cnt, W);
        check({name, "_done_pulses"}, n_done - d0, 1);
    endtask

    initial begin
        int d0;
        int t;
        int c1;
        int c2;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;

        // 1. reset for two cycles, then idle stability
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_z", z, 8'h00);
            check("rst_zero", zero, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
        end

        // 2, 3. each operation once
        run_op(2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
        run_op(2'b10, 8'hAA, 8'hAA, 8'h00, 1'b1, "xor");
        run_op(2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0, "or");
        run_op(2'b11, 8'h00, 8'h00, 8'hFF, 1'b0, "nor");

        // 4. start during RUN is ignored
        @(negedge clk);
        d0 = n_done;
        op = 2'b00; a = 8'hFF; b = 8'h81; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op = 2'b01; a = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        check("ign_z", z, 8'h81);
        repeat (15) @(negedge clk);
        check("ign_pulses", n_done - d0, 1);
        check("ign_idle", busy, 1'b0);

        // 5. start held high: one result every W+1 cycles
        @(negedge clk);
        op = 2'b10; a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        wait_done("b2b_done0");
        c1 = cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy_after_done", busy, 1'b1);
            wait_done("b2b_done");
            c2 = cyc;
            check("b2b_period", c2 - c1, W + 1);
            check("b2b_z", z, 8'h33);
            c1 = c2;
        end
        start = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("b2b_drain", busy, 1'b0);
        repeat (2) @(negedge clk);

        // 6. reset mid-RUN aborts
        d0 = n_done;
        op = 2'b00; a = 8'hFF; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_z", z, 8'h00);
        check("abort_zero", zero, 1'b1);
        repeat (12) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        run_op(2'b00, 8'h55, 8'hFF, 8'h55, 1'b0, "post_abort");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/bit_serial_logic_ctrl.md
Name: bit_serial_logic_ctrl

Overview:
Sequencer that time-shares a single 1-bit logic cell (AND/OR/XOR/NOR) across a WIDTH-bit operand pair, one bit per clock, LSB first. It replaces a WIDTH-wide parallel logic slice when area matters. It sits beside the ALU as a multi-cycle logic unit with a start/busy/done handshake to the processor control.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the block is not busy.
op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
A  input  WIDTH  operand A; latched on start acceptance.
B  input  WIDTH  operand B; latched on start acceptance.
busy  output  1  high while bits are being processed.
done  output  1  single-cycle pulse when a new Z is valid.
Z  output  WIDTH  registered result; holds until the next completion.
ZERO  output  1  registered flag, (Z == 0), updated together with Z.

Behaviour:
- Reset (synchronous, takes priority over all else): state=IDLE, busy=0, done=0, Z=0, ZERO=1, counter=0, internal operand/result registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, latch A, B and op into A_r, B_r and op_r; counter=0; go to RUN with busy=1.
  - RUN: on each edge, write f(op_r, A_r[cnt], B_r[cnt]) into res[cnt] and increment cnt. On the edge where cnt==WIDTH-1: load Z from the completed res (including the final bit), update ZERO, and go to DONE with busy=0 and done=1.
  - DONE: lasts exactly 1 cycle with done=1. If start=1 in this cycle, the request is accepted exactly as in IDLE (back-to-back operation). Otherwise return to IDLE.
- Latency: done is high in the cycle that begins WIDTH edges after the accepting edge. Back-to-back throughput is one result every WIDTH+1 cycles.
- busy is high for exactly WIDTH cycles per operation.
- start while busy=1 is ignored; no queuing. A, B and op changes during RUN have no effect.
- Z and ZERO never show partial results; the previous result stays visible during RUN.
- Reset during RUN aborts the operation: no done pulse, Z=0.
- The counter never exceeds WIDTH-1; no wrap-around occurs within RUN.

Decomposition:
- Shared package holds:
  - OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11.
  - State encodings S_IDLE, S_RUN, S_DONE (2 bits).
- One combinational sub-module, logic_cell_1bit (inputs a, b, op; output y), instantiated once. It is the shared resource being sequenced.
- FSM, counter and registers live in the top level.

Test Plan:
1. Hold reset for 2 cycles, then release -> Z=0, ZERO=1, busy=0, done=0. Outputs stay stable with start=0.
2. WIDTH=8: A=8'hF0, B=8'h3C, op=00, one-cycle start pulse -> busy high for 8 cycles, then a single done pulse, Z=8'h30, ZERO=0.
3. Run the remaining ops in sequence:
   - XOR with A=B=8'hAA -> Z=8'h00, ZERO=1.
   - OR with 8'h0F and 8'hF0 -> Z=8'hFF.
   - NOR with 8'h00 and 8'h00 -> Z=8'hFF.
4. Start AND with A=8'hFF, B=8'h81. At cycle 3 of RUN, pulse start with op=01 and A=8'h00 -> only one done pulse, Z=8'h81, and no second operation begins.
5. Hold start high continuously with fixed operands -> done pulses every 9 cycles, busy low only during the done cycles, Z identical each time.
6. Assert reset at cycle 4 of RUN -> next cycle busy=0, Z=0, no done pulse. A following AND of 8'h55 and 8'hFF gives Z=8'h55.
